// File: rtl/demux_serial_4lanes_pkg.sv
// Shared definitions for the 4-lane byte mux/demux pair: default widths, idle filler and slot order.
// Both ends import this package so the lane order of the serial stream is defined in one place.
package demux_serial_4lanes_pkg;

  localparam int                            DEFAULT_BUS_WIDTH  = 8;
  localparam logic [DEFAULT_BUS_WIDTH-1:0]  DEFAULT_IDLE_VALUE = 8'h00;

  // Slot order within a frame: lane 0 travels first, lane 3 closes the frame.
  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_e;

  // A frame marker forces the current slot to lane 0 regardless of the free-running phase.
  function automatic lane_e slot_lane(input logic start, input logic [1:0] fase);
    return start ? LANE0 : lane_e'(fase);
  endfunction

endpackage

// File: rtl/contador_fase.sv
// Free-running 2-bit slot phase counter; a frame marker reloads it so the next slot is lane 1.
// Flags a marker that arrives mid-frame, both immediately (realign) and as a registered pulse.
module contador_fase
  import demux_serial_4lanes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio_trama,
  output logic [1:0] fase,
  output logic       realign,
  output logic       error_alineacion
);

  logic [1:0] fase_next;

  // NOTE: every signal assigned in an always_comb gets a value on every path, which is
  // what keeps synthesis from inferring a latch; here both are unconditional.
  always_comb begin
    realign   = inicio_trama && (fase != 2'd0);
    fase_next = inicio_trama ? 2'd1 : fase + 2'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fase             <= 2'd0;
      error_alineacion <= 1'b0;
    end else begin
      fase             <= fase_next;
      error_alineacion <= realign;
    end
  end

endmodule

// File: rtl/demux_serial_4lanes.sv
// Receive side of the 4-lane byte mux: stages lanes 0..2 of each frame and commits all four
// lanes together on the lane-3 slot, holding the parallel outputs for the whole next frame.
module demux_serial_4lanes
  import demux_serial_4lanes_pkg::*;
#(
  parameter int                    BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  parameter logic [BUS_WIDTH-1:0]  IDLE_VALUE = DEFAULT_IDLE_VALUE
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] Entrada,
  input  logic                 validEntrada,
  input  logic                 inicioTrama,
  output logic [BUS_WIDTH-1:0] Salida0,
  output logic [BUS_WIDTH-1:0] Salida1,
  output logic [BUS_WIDTH-1:0] Salida2,
  output logic [BUS_WIDTH-1:0] Salida3,
  output logic                 validSalida0,
  output logic                 validSalida1,
  output logic                 validSalida2,
  output logic                 validSalida3,
  output logic                 errorAlineacion
);

  localparam int STAGED_LANES = 3;

  logic [1:0]           fase;
  logic                 realign;
  lane_e                lane;
  logic                 commit;
  logic [BUS_WIDTH-1:0] slot_data;

  logic [BUS_WIDTH-1:0] stage_data [STAGED_LANES];
  logic [STAGED_LANES-1:0] stage_valid;

  contador_fase u_contador_fase (
    .clk              (clk_4f),
    .rst_n            (reset),
    .inicio_trama     (inicioTrama),
    .fase             (fase),
    .realign          (realign),
    .error_alineacion (errorAlineacion)
  );

  // Invalid slots carry the idle filler so a lane never exposes whatever was on the wire.
  always_comb begin
    lane      = slot_lane(inicioTrama, fase);
    commit    = (lane == LANE3);
    slot_data = validEntrada ? Entrada : IDLE_VALUE;
  end

  // NOTE: the staging array is a few flops rather than a RAM, so it is reset like any other
  // register; a reset then throws away any half-built frame.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGED_LANES; i++) begin
        stage_data[i] <= IDLE_VALUE;
      end
      stage_valid <= '0;
    end else if (commit) begin
      for (int i = 0; i < STAGED_LANES; i++) begin
        stage_data[i] <= IDLE_VALUE;
      end
      stage_valid <= '0;
    end else begin
      // A mid-frame marker aborts the partial frame; the lane-0 write below still wins.
      for (int i = 0; i < STAGED_LANES; i++) begin
        if (int'(lane) == i) begin
          stage_data[i]  <= slot_data;
          stage_valid[i] <= validEntrada;
        end else if (realign) begin
          stage_data[i]  <= IDLE_VALUE;
          stage_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      Salida0      <= IDLE_VALUE;
      Salida1      <= IDLE_VALUE;
      Salida2      <= IDLE_VALUE;
      Salida3      <= IDLE_VALUE;
      validSalida0 <= 1'b0;
      validSalida1 <= 1'b0;
      validSalida2 <= 1'b0;
      validSalida3 <= 1'b0;
    end else if (commit) begin
      Salida0      <= stage_data[0];
      Salida1      <= stage_data[1];
      Salida2      <= stage_data[2];
      Salida3      <= slot_data;
      validSalida0 <= stage_valid[0];
      validSalida1 <= stage_valid[1];
      validSalida2 <= stage_valid[2];
      validSalida3 <= validEntrada;
    end
  end

endmodule

// File: tb/tb_demux_serial_4lanes.sv
// Directed bench for demux_serial_4lanes: each slot pushes the expected post-edge output state
// into a scoreboard, and a negedge monitor pops and compares it when that cycle is presented.
module tb_demux_serial_4lanes;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] Entrada;
  logic       validEntrada;
  logic       inicioTrama;
  logic [7:0] Salida0, Salida1, Salida2, Salida3;
  logic       validSalida0, validSalida1, validSalida2, validSalida3;
  logic       errorAlineacion;

  typedef struct {
    int unsigned stamp;
    string       name;
    logic [31:0] data;   // {Salida3, Salida2, Salida1, Salida0}
    logic [3:0]  valid;  // {validSalida3 .. validSalida0}
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned edge_n = 0;
  int          tests  = 0;
  int          fails  = 0;

  demux_serial_4lanes dut (
    .clk_4f          (clk_4f),
    .reset           (reset),
    .Entrada         (Entrada),
    .validEntrada    (validEntrada),
    .inicioTrama     (inicioTrama),
    .Salida0         (Salida0),
    .Salida1         (Salida1),
    .Salida2         (Salida2),
    .Salida3         (Salida3),
    .validSalida0    (validSalida0),
    .validSalida1    (validSalida1),
    .validSalida2    (validSalida2),
    .validSalida3    (validSalida3),
    .errorAlineacion (errorAlineacion)
  );

  always #5 clk_4f = ~clk_4f;

  always @(posedge clk_4f) edge_n <= edge_n + 1;

  function automatic logic [36:0] observed();
    return {Salida3, Salida2, Salida1, Salida0,
            validSalida3, validSalida2, validSalida1, validSalida0, errorAlineacion};
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got data=%h valid=%b err=%b, expected data=%h valid=%b err=%b",
               name, act[36:5], act[4:1], act[0], exp[36:5], exp[4:1], exp[0]);
    end
  endtask

  // Monitor: each expectation is due on the negedge following the edge that consumed its slot.
  always @(negedge clk_4f) begin
    if (sb.size() > 0 && sb[0].stamp <= edge_n) begin
      cur = sb.pop_front();
      if (cur.stamp != edge_n) begin
        tests++;
        fails++;
        $display("FAIL %s: compared at edge %0d, expected at edge %0d", cur.name, edge_n, cur.stamp);
      end else begin
        check(cur.name, observed(), {cur.data, cur.valid, cur.err});
      end
    end
  end

  // Issue one slot at the current negedge and queue the output state expected after its edge.
  task automatic step(input logic [7:0] d, input logic v, input logic s, input string name,
                      input logic [31:0] exp_data, input logic [3:0] exp_valid, input logic exp_err);
    exp_t e;
    e.stamp = edge_n + 1;
    e.name  = name;
    e.data  = exp_data;
    e.valid = exp_valid;
    e.err   = exp_err;
    sb.push_back(e);
    Entrada      = d;
    validEntrada = v;
    inicioTrama  = s;
    @(negedge clk_4f);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    Entrada      = 8'h00;
    validEntrada = 1'b0;
    inicioTrama  = 1'b0;
    @(negedge clk_4f);

    // Reset held for three cycles: idle outputs, no error.
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, "reset_hold", 32'h0, 4'h0, 1'b0);
    reset = 1'b1;

    // Full frame aligned to phase 0: marker here must not raise an error.
    step(8'hAA, 1'b1, 1'b1, "full_s0",     32'h00000000, 4'h0, 1'b0);
    step(8'hBB, 1'b1, 1'b0, "full_s1",     32'h00000000, 4'h0, 1'b0);
    step(8'hCC, 1'b1, 1'b0, "full_s2",     32'h00000000, 4'h0, 1'b0);
    step(8'hDD, 1'b1, 1'b0, "full_commit", 32'hDDCCBBAA, 4'hF, 1'b0);

    // Sparse frame, free-running; invalid slots carry junk that must be replaced by idle.
    step(8'h11, 1'b1, 1'b0, "sparse_hold0",  32'hDDCCBBAA, 4'hF, 1'b0);
    step(8'hEE, 1'b0, 1'b0, "sparse_hold1",  32'hDDCCBBAA, 4'hF, 1'b0);
    step(8'h33, 1'b1, 1'b0, "sparse_hold2",  32'hDDCCBBAA, 4'hF, 1'b0);
    step(8'h44, 1'b0, 1'b0, "sparse_commit", 32'h00330011, 4'h5, 1'b0);

    // Back-to-back frames: outputs change exactly every fourth cycle.
    step(8'h01, 1'b1, 1'b1, "b2b_a_hold0",  32'h00330011, 4'h5, 1'b0);
    step(8'h02, 1'b1, 1'b0, "b2b_a_hold1",  32'h00330011, 4'h5, 1'b0);
    step(8'h03, 1'b1, 1'b0, "b2b_a_hold2",  32'h00330011, 4'h5, 1'b0);
    step(8'h04, 1'b1, 1'b0, "b2b_a_commit", 32'h04030201, 4'hF, 1'b0);
    step(8'h05, 1'b1, 1'b1, "b2b_b_hold0",  32'h04030201, 4'hF, 1'b0);
    step(8'h06, 1'b1, 1'b0, "b2b_b_hold1",  32'h04030201, 4'hF, 1'b0);
    step(8'h07, 1'b1, 1'b0, "b2b_b_hold2",  32'h04030201, 4'hF, 1'b0);
    step(8'h08, 1'b1, 1'b0, "b2b_b_commit", 32'h08070605, 4'hF, 1'b0);

    // Marker at phase 2: one-cycle error, partial frame dropped, realigned frame commits.
    step(8'h50, 1'b1, 1'b0, "mis2_f0",     32'h08070605, 4'hF, 1'b0);
    step(8'h51, 1'b1, 1'b0, "mis2_f1",     32'h08070605, 4'hF, 1'b0);
    step(8'h9A, 1'b1, 1'b1, "mis2_err",    32'h08070605, 4'hF, 1'b1);
    step(8'h9B, 1'b1, 1'b0, "mis2_pulse1", 32'h08070605, 4'hF, 1'b0);
    step(8'h9C, 1'b1, 1'b0, "mis2_hold",   32'h08070605, 4'hF, 1'b0);
    step(8'h9D, 1'b1, 1'b0, "mis2_commit", 32'h9D9C9B9A, 4'hF, 1'b0);

    // Marker at phase 3: must abort rather than commit, then a sparse realigned frame.
    step(8'h60, 1'b1, 1'b0, "mis3_f0",     32'h9D9C9B9A, 4'hF, 1'b0);
    step(8'h61, 1'b1, 1'b0, "mis3_f1",     32'h9D9C9B9A, 4'hF, 1'b0);
    step(8'h62, 1'b1, 1'b0, "mis3_f2",     32'h9D9C9B9A, 4'hF, 1'b0);
    step(8'h70, 1'b1, 1'b1, "mis3_err",    32'h9D9C9B9A, 4'hF, 1'b1);
    step(8'h71, 1'b0, 1'b0, "mis3_pulse1", 32'h9D9C9B9A, 4'hF, 1'b0);
    step(8'h72, 1'b0, 1'b0, "mis3_hold",   32'h9D9C9B9A, 4'hF, 1'b0);
    step(8'h73, 1'b1, 1'b0, "mis3_commit", 32'h73000070, 4'h9, 1'b0);

    // Reset mid-frame after lanes 0 and 1 are staged: outputs clear without a clock edge.
    step(8'hB0, 1'b1, 1'b0, "rst_mid_l0", 32'h73000070, 4'h9, 1'b0);
    step(8'hB1, 1'b1, 1'b0, "rst_mid_l1", 32'h73000070, 4'h9, 1'b0);
    #2 reset = 1'b0;
    #1 check("rst_async", observed(), 37'h0);
    step(8'hB2, 1'b1, 1'b0, "rst_mid_held", 32'h0, 4'h0, 1'b0);
    reset = 1'b1;
    step(8'hC0, 1'b1, 1'b0, "post_rst_l0",     32'h0, 4'h0, 1'b0);
    step(8'hC1, 1'b0, 1'b0, "post_rst_l1",     32'h0, 4'h0, 1'b0);
    step(8'hC2, 1'b0, 1'b0, "post_rst_l2",     32'h0, 4'h0, 1'b0);
    step(8'hC3, 1'b1, 1'b0, "post_rst_commit", 32'hC30000C0, 4'h9, 1'b0);
    step(8'h00, 1'b0, 1'b0, "post_rst_hold",   32'hC30000C0, 4'h9, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk_4f);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
